pattern_frame_tx: RTL



---
 rtl/pattern_frame_tx_pkg.sv | 30 +++
 rtl/pattern_frame_tx_if.sv | 31 +++
 rtl/pattern_frame_tx_piso_shift.sv | 35 +++
 rtl/pattern_frame_tx.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pattern_frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pattern_frame_tx_pkg
// Purpose  : Shared constants for the 11011 framing link (transmitter side and
//            detector side agree on the sync pattern through this package).
// Revision : 1.0 - initial release
// ============================================================================
package pattern_frame_tx_pkg;

    // Transmitter FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic [1:0] ST_PARITY = 2'd3;

    // Default sync word shared with the receiving detector
    localparam int                    SYNC_W_DEF   = 5;
    localparam logic [SYNC_W_DEF-1:0] SYNC_PAT_DEF = 5'b11011;

    // Bit counter width: clog2 of the longer of the two counted phases, at least 1
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : pattern_frame_tx_if
// Purpose  : Payload handshake and serial-output bundle of the frame
//            transmitter. master = payload source / link observer,
//            slave = transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface pattern_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic              out;
    logic              out_valid;
    logic              sync_phase;
    logic              frame_done;
    logic              busy;

    modport master (
        output data_in, data_valid,
        input  data_ready, out, out_valid, sync_phase, frame_done, busy
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, out, out_valid, sync_phase, frame_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/pattern_frame_tx_piso_shift.sv
`default_nettype none
// ============================================================================
// Module   : piso_shift
// Purpose  : Parallel-load, MSB-first shift register. Load wins over shift;
//            zeros are shifted in at the LSB end.
// Revision : 1.0 - initial release
// ============================================================================
module piso_shift #(
    parameter int W = 12
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         load_i,
    input  wire logic         shift_i,
    input  wire logic [W-1:0] par_i,
    output logic              ser_o
);

    logic [W-1:0] sh_q;

    // Parallel load or single-bit left shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
        end else if (load_i) begin
            sh_q <= par_i;
        end else if (shift_i) begin
            sh_q <= {sh_q[W-2:0], 1'b0};
        end
    end

    assign ser_o = sh_q[W-1];

endmodule
`default_nettype wire

// File: rtl/pattern_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : pattern_frame_tx
// Purpose  : Serial framing transmitter: sync pattern, MSB-first payload, even
//            parity bit, one bit per clock, back-to-back frames supported.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_frame_tx
    import pattern_frame_tx_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
    parameter logic              IDLE_BIT = 1'b0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pattern_frame_tx_if.slave bus
);

    localparam int CNT_W = cnt_width(SYNC_W, DATA_W);
    // The first sync bit goes straight to out on acceptance, so the shifter
    // only holds the remaining sync bits followed by the payload.
    localparam int SH_W  = SYNC_W - 1 + DATA_W;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             parity_q, parity_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             sync_phase_q, sync_phase_d;
    logic             frame_done_q, frame_done_d;
    logic             busy_q, busy_d;

    logic             w_ready;
    logic             w_accept;
    logic             w_load;
    logic             w_shift;
    logic             w_ser;
    logic [SH_W-1:0]  w_load_val;

    assign w_ready    = !rst && ((state_q == ST_IDLE) || (state_q == ST_PARITY));
    assign w_accept   = w_ready && bus.data_valid;
    assign w_load_val = {SYNC_PAT[SYNC_W-2:0], bus.data_in};

    piso_shift #(.W(SH_W)) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_load),
        .shift_i (w_shift),
        .par_i   (w_load_val),
        .ser_o   (w_ser)
    );

    // Next-state, next-output and parity accumulation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        parity_d     = parity_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        sync_phase_d = sync_phase_q;
        frame_done_d = 1'b0;
        busy_d       = busy_q;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (state_q)
            ST_IDLE, ST_PARITY: begin
                if (w_accept) begin
                    state_d      = ST_SYNC;
                    cnt_d        = CNT_W'(SYNC_W - 1);
                    parity_d     = 1'b0;
                    out_d        = SYNC_PAT[SYNC_W-1];
                    out_valid_d  = 1'b1;
                    sync_phase_d = 1'b1;
                    busy_d       = 1'b1;
                    w_load       = 1'b1;
                end else begin
                    state_d      = ST_IDLE;
                    out_d        = IDLE_BIT;
                    out_valid_d  = 1'b0;
                    sync_phase_d = 1'b0;
                    busy_d       = 1'b0;
                end
            end
            ST_SYNC: begin
                w_shift = 1'b1;
                out_d   = w_ser;
                if (cnt_q == '0) begin
                    state_d      = ST_DATA;
                    cnt_d        = CNT_W'(DATA_W - 1);
                    sync_phase_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DATA: begin
                // out_q is the payload bit currently on the line
                parity_d = parity_q ^ out_q;
                if (cnt_q == '0) begin
                    state_d      = ST_PARITY;
                    out_d        = parity_q ^ out_q;
                    frame_done_d = 1'b1;
                end else begin
                    w_shift = 1'b1;
                    out_d   = w_ser;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            parity_q     <= 1'b0;
            out_q        <= IDLE_BIT;
            out_valid_q  <= 1'b0;
            sync_phase_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            parity_q     <= parity_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            sync_phase_q <= sync_phase_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.data_ready = w_ready;
    assign bus.out        = out_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.sync_phase = sync_phase_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

endmodule
`default_nettype wire
